psum_tile_scheduler: RTL and testbench

Sequences the partial-sum controller through a full output job: reduction passes over K input-channel tiles, and within each pass one STORE run per output-column tile. It drives the controller's start, first-psum, output-load, psum ping-pong select, output-buffer select and base address. It also self-times STORE runs and waits on the controller's output-load completion. It sits between the top-level job FSM and the psum controller, beside the systolic array.

---
 rtl/psum_tile_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_psum_tile_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/psum_tile_scheduler.sv
// Partial-sum tile scheduler: walks K reduction passes x C column tiles, issuing one
// psum-controller STORE run per tile. Optional perf counters are enabled by PSUM_SCHED_PERF_EN.
module psum_tile_scheduler #(
    parameter int ROW               = 8,
    parameter int COL               = 8,
    parameter int O_BRAM_ADDR_WIDTH = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [7:0]                   A,
    input  logic [7:0]                   C,
    input  logic [7:0]                   L,
    input  logic [7:0]                   K,
    output logic                         busy,
    output logic                         done,
    output logic                         cfg_err,
    output logic                         ctrl_start,
    output logic                         ctrl_first_psum,
    output logic                         ctrl_outputload,
    output logic                         ctrl_psum_sel,
    output logic                         ctrl_o_sel,
    output logic [O_BRAM_ADDR_WIDTH:0]   ctrl_psum_baseaddr,
    output logic [7:0]                   ctrl_A,
    output logic [7:0]                   ctrl_C,
    output logic [7:0]                   ctrl_L,
    input  logic                         outputload_fin
`ifdef PSUM_SCHED_PERF_EN
    ,
    output logic [31:0]                  perf_cycles,
    output logic [15:0]                  perf_passes
`endif
);

    localparam int          BA_W  = O_BRAM_ADDR_WIDTH + 1;
    localparam logic [15:0] ROW16 = 16'(ROW);

    if (ROW < 1 || COL < 1) begin : g_param_check
        $error("psum_tile_scheduler: ROW and COL must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ISSUE      = 3'd1,
        STORE_WAIT = 3'd2,
        OUT_WAIT   = 3'd3,
        FIN        = 3'd4
    } state_t;

    state_t      state_r;
    logic [7:0]  k_r;
    logic [7:0]  n_r;
    logic [7:0]  k_dim_r;
    logic [15:0] wait_r;

    logic [7:0]  n_next_s;
    logic [7:0]  k_next_s;
    logic        pass_end_s;
    logic        dims_ok_s;
    logic        accept_s;
    logic [15:0] w_load_s;

    assign dims_ok_s = (A != 8'd0) && (C != 8'd0) && (L != 8'd0) && (K != 8'd0);
    assign accept_s  = (state_r == IDLE) && start && dims_ok_s;

    // STORE duration plus one cycle for the controller to return to idle
    assign w_load_s = 16'({8'd0, ctrl_L} * ROW16) + ROW16 + 16'd1;

    // Tile indices for the run that follows the current one
    always_comb begin
        n_next_s   = 8'd0;
        k_next_s   = k_r;
        pass_end_s = 1'b0;
        if (n_r < (ctrl_C - 8'd1)) begin
            n_next_s   = n_r + 8'd1;
            k_next_s   = k_r;
            pass_end_s = 1'b0;
        end else begin
            n_next_s   = 8'd0;
            k_next_s   = k_r + 8'd1;
            pass_end_s = 1'b1;
        end
    end

    // Job sequencer with registered controller-facing outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r            <= IDLE;
            k_r                <= 8'd0;
            n_r                <= 8'd0;
            k_dim_r            <= 8'd0;
            wait_r             <= 16'd0;
            busy               <= 1'b0;
            done               <= 1'b0;
            cfg_err            <= 1'b0;
            ctrl_start         <= 1'b0;
            ctrl_first_psum    <= 1'b0;
            ctrl_outputload    <= 1'b0;
            ctrl_psum_sel      <= 1'b0;
            ctrl_o_sel         <= 1'b0;
            ctrl_psum_baseaddr <= '0;
            ctrl_A             <= 8'd0;
            ctrl_C             <= 8'd0;
            ctrl_L             <= 8'd0;
        end else begin
            ctrl_start <= 1'b0;
            done       <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        ctrl_A             <= A;
                        ctrl_C             <= C;
                        ctrl_L             <= L;
                        k_dim_r            <= K;
                        k_r                <= 8'd0;
                        n_r                <= 8'd0;
                        ctrl_psum_sel      <= 1'b0;
                        busy               <= 1'b1;
                        cfg_err            <= 1'b0;
                        ctrl_start         <= 1'b1;
                        ctrl_first_psum    <= 1'b1;
                        ctrl_outputload    <= (K == 8'd1) && (C == 8'd1);
                        ctrl_psum_baseaddr <= '0;
                        state_r            <= ISSUE;
                    end else if (start) begin
                        cfg_err <= 1'b1;
                        done    <= 1'b1;
                    end
                end
                ISSUE: begin
                    wait_r  <= w_load_s;
                    state_r <= ctrl_outputload ? OUT_WAIT : STORE_WAIT;
                end
                STORE_WAIT: begin
                    wait_r <= wait_r - 16'd1;
                    if (wait_r == 16'd1) begin
                        n_r                <= n_next_s;
                        k_r                <= k_next_s;
                        if (pass_end_s) begin
                            ctrl_psum_sel <= ~ctrl_psum_sel;
                        end
                        ctrl_start         <= 1'b1;
                        ctrl_first_psum    <= (k_next_s == 8'd0);
                        ctrl_outputload    <= (k_next_s == (k_dim_r - 8'd1)) &&
                                              (n_next_s == (ctrl_C - 8'd1));
                        ctrl_psum_baseaddr <= BA_W'({24'd0, n_next_s} * ROW);
                        state_r            <= ISSUE;
                    end
                end
                OUT_WAIT: begin
                    if (outputload_fin) begin
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        ctrl_o_sel <= ~ctrl_o_sel;
                        state_r    <= FIN;
                    end
                end
                FIN: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef PSUM_SCHED_PERF_EN
    // Per-job busy-cycle and run counters, restarted on each accepted job
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles <= 32'd0;
            perf_passes <= 16'd0;
        end else if (accept_s) begin
            perf_cycles <= 32'd0;
            perf_passes <= 16'd0;
        end else begin
            if (busy && (perf_cycles != 32'hFFFF_FFFF)) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
            if (ctrl_start) begin
                perf_passes <= perf_passes + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_psum_tile_scheduler.sv
// Directed bench for psum_tile_scheduler: table of jobs with hand-computed run counts,
// spacing and buffer selects, plus hand sequences for config error and mid-job reset.
module tb_psum_tile_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dim_a = 8'd0, dim_c = 8'd0, dim_l = 8'd0, dim_k = 8'd0;
    logic       outputload_fin = 1'b0;
    logic       busy, done, cfg_err, ctrl_start, ctrl_first_psum, ctrl_outputload;
    logic       ctrl_psum_sel, ctrl_o_sel;
    logic [7:0] ctrl_psum_baseaddr, ctrl_A, ctrl_C, ctrl_L;
`ifdef PSUM_SCHED_PERF_EN
    logic [31:0] perf_cycles;
    logic [15:0] perf_passes;
`endif

    psum_tile_scheduler #(.ROW(8), .COL(8), .O_BRAM_ADDR_WIDTH(7)) dut (
        .clk(clk), .rst(rst), .start(start),
        .A(dim_a), .C(dim_c), .L(dim_l), .K(dim_k),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .ctrl_start(ctrl_start), .ctrl_first_psum(ctrl_first_psum),
        .ctrl_outputload(ctrl_outputload), .ctrl_psum_sel(ctrl_psum_sel),
        .ctrl_o_sel(ctrl_o_sel), .ctrl_psum_baseaddr(ctrl_psum_baseaddr),
        .ctrl_A(ctrl_A), .ctrl_C(ctrl_C), .ctrl_L(ctrl_L),
        .outputload_fin(outputload_fin)
`ifdef PSUM_SCHED_PERF_EN
        , .perf_cycles(perf_cycles), .perf_passes(perf_passes)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] base;
        logic       first;
        logic       oload;
        logic       psel;
    } pulse_t;

    typedef struct {
        logic [7:0] a, c, l, k;
        int         fin_delay;
        bit         inject;
        int         exp_pulses;
        int         exp_space;
        bit         exp_osel;
    } job_t;

    typedef struct {
        logic [7:0] base;
        logic       first;
        logic       psel;
        logic       oload;
    } pexp_t;

    pulse_t pq[$];
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ctrl_start === 1'b1) begin
            pq.push_back('{cyc, ctrl_psum_baseaddr, ctrl_first_psum, ctrl_outputload, ctrl_psum_sel});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_job(input job_t j);
        int start_cyc;
        bit got;
        pq.delete();
        @(negedge clk);
        dim_a = j.a; dim_c = j.c; dim_l = j.l; dim_k = j.k;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("cfg_err_cleared", cfg_err, 0);
        got = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (ctrl_start === 1'b1 && ctrl_outputload === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (j.inject && i == 40) begin
                dim_a = 8'd9; dim_c = 8'd9; dim_l = 8'd9; dim_k = 8'd9;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("final_run_seen", got, 1);
        repeat (j.fin_delay) @(negedge clk);
        outputload_fin = 1'b1;
        @(negedge clk);
        outputload_fin = 1'b0;
        chk("done_after_fin", done, 1);
        chk("busy_low_in_fin", busy, 0);
        chk("o_sel_after_job", ctrl_o_sel, j.exp_osel);
        dim_a = 8'd1; dim_c = 8'd1; dim_l = 8'd1; dim_k = 8'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_fin_ignored", {busy, ctrl_start}, 0);
        chk("done_one_cycle", done, 0);
        chk("pulse_count", pq.size(), j.exp_pulses);
        if (pq.size() > 0) chk("start_latency", pq[0].cyc - start_cyc, 1);
        for (int i = 1; i < pq.size(); i++) begin
            chk("issue_spacing", pq[i].cyc - pq[i-1].cyc, j.exp_space);
        end
        chk("ctrl_A_held", ctrl_A, j.a);
        chk("ctrl_C_held", ctrl_C, j.c);
        chk("ctrl_L_held", ctrl_L, j.l);
`ifdef PSUM_SCHED_PERF_EN
        chk("perf_passes", perf_passes, j.exp_pulses);
`endif
    endtask

    job_t  jobs[4];
    pexp_t pexp[6];

    initial begin
        int cnt;
        bit got;
        jobs[0] = '{8'd1, 8'd1, 8'd1, 8'd1, 32'd20, 1'b0, 32'd1, 32'd0,  1'b1};
        jobs[1] = '{8'd2, 8'd3, 8'd2, 8'd2, 32'd20, 1'b0, 32'd6, 32'd26, 1'b0};
        jobs[2] = '{8'd3, 8'd2, 8'd1, 8'd3, 32'd5,  1'b0, 32'd6, 32'd18, 1'b1};
        jobs[3] = '{8'd2, 8'd3, 8'd2, 8'd2, 32'd3,  1'b1, 32'd6, 32'd26, 1'b0};
        pexp[0] = '{8'd0,  1'b1, 1'b0, 1'b0};
        pexp[1] = '{8'd8,  1'b1, 1'b0, 1'b0};
        pexp[2] = '{8'd16, 1'b1, 1'b0, 1'b0};
        pexp[3] = '{8'd0,  1'b0, 1'b1, 1'b0};
        pexp[4] = '{8'd8,  1'b0, 1'b1, 1'b0};
        pexp[5] = '{8'd16, 1'b0, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done_cfg_start", {done, cfg_err, ctrl_start}, 0);
        chk("rst_sels", {ctrl_psum_sel, ctrl_o_sel, ctrl_first_psum, ctrl_outputload}, 0);
        chk("rst_base_dims", {ctrl_psum_baseaddr, ctrl_A, ctrl_C, ctrl_L}, 0);
        rst = 1'b0;

        for (int j = 0; j < 4; j++) begin
            if (j == 3) begin
                pq.delete();
                @(negedge clk);
                dim_a = 8'd1; dim_c = 8'd0; dim_l = 8'd1; dim_k = 8'd1;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("cfg_err_set", cfg_err, 1);
                chk("cfg_done_pulse", done, 1);
                chk("cfg_no_busy", busy, 0);
                @(negedge clk);
                chk("cfg_done_one_cycle", done, 0);
                repeat (5) @(negedge clk);
                chk("cfg_no_ctrl_start", pq.size(), 0);
                chk("cfg_o_sel_unchanged", ctrl_o_sel, 1);
            end
            run_job(jobs[j]);
            if (j == 0 && pq.size() == 1) begin
                chk("single_first", pq[0].first, 1);
                chk("single_oload", pq[0].oload, 1);
                chk("single_base", pq[0].base, 0);
            end
            if (j == 1 && pq.size() == 6) begin
                for (int i = 0; i < 6; i++) begin
                    chk("run_base", pq[i].base, pexp[i].base);
                    chk("run_first_psum", pq[i].first, pexp[i].first);
                    chk("run_psum_sel", pq[i].psel, pexp[i].psel);
                    chk("run_outputload", pq[i].oload, pexp[i].oload);
                end
            end
        end

        // Reset during the second run's STORE_WAIT, with a start coincident with rst
        @(negedge clk);
        dim_a = 8'd2; dim_c = 8'd3; dim_l = 8'd2; dim_k = 8'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ctrl_start === 1'b1) cnt++;
            if (cnt == 2) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("second_run_seen", got, 1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_outputs", {done, cfg_err, ctrl_start, ctrl_psum_sel, ctrl_o_sel,
                               ctrl_first_psum, ctrl_outputload}, 0);
        chk("midrst_base_dims", {ctrl_psum_baseaddr, ctrl_A, ctrl_C, ctrl_L}, 0);
        rst = 1'b0;
        start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) cnt++;
        end
        chk("midrst_no_done_no_busy", cnt, 0);
        run_job(jobs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
